hdmi_pll_recfg_seq: RTL and testbench

HDMI_PLL_RECFG_SEQ -- requirements
Module: hdmi_pll_recfg_seq

---
 rtl/hdmi_pll_pkg.sv | 67 ++++++
 rtl/hdmi_pll_div_enc.sv | 13 +
 rtl/hdmi_pll_recfg_seq.sv | 136 +++++++++++++
 tb/tb_hdmi_pll_recfg_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pll_pkg.sv
// rtl/hdmi_pll_pkg.sv - register map, sequencer states and divider encoding for the HDMI PLL reconfig sequencer
// Items under HDMI_PLL_BW_EN exist only when bandwidth/charge-pump programming is built in.
package hdmi_pll_pkg;

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_N     = 6'd3;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C0    = 6'd5;
  localparam logic [5:0] ADDR_K     = 6'd7;
`ifdef HDMI_PLL_BW_EN
  localparam logic [5:0] ADDR_BW    = 6'd8;
  localparam logic [5:0] ADDR_CP    = 6'd9;
`endif

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_W_MODE    = 4'd1;
  localparam logic [3:0] S_W_N       = 4'd2;
  localparam logic [3:0] S_W_M       = 4'd3;
  localparam logic [3:0] S_W_C0      = 4'd4;
  localparam logic [3:0] S_W_K       = 4'd5;
`ifdef HDMI_PLL_BW_EN
  localparam logic [3:0] S_W_BW      = 4'd6;
  localparam logic [3:0] S_W_CP      = 4'd7;
`endif
  localparam logic [3:0] S_W_START   = 4'd8;
  localparam logic [3:0] S_WAIT_LOCK = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;
  localparam logic [3:0] S_ERR       = 4'd11;

  typedef enum logic [3:0] {
    IDLE      = S_IDLE,
    W_MODE    = S_W_MODE,
    W_N       = S_W_N,
    W_M       = S_W_M,
    W_C0      = S_W_C0,
    W_K       = S_W_K,
`ifdef HDMI_PLL_BW_EN
    W_BW      = S_W_BW,
    W_CP      = S_W_CP,
`endif
    W_START   = S_W_START,
    WAIT_LOCK = S_WAIT_LOCK,
    DONE      = S_DONE,
    ERR       = S_ERR
  } state_e;

  // Counter register: high count in [15:8], low count in [7:0], odd-division
  // flag in bit 17, bypass in bit 16. A ratio of 1 is pure bypass, all else zero.
  function automatic logic [31:0] div_encode(input logic [8:0] d);
    logic [31:0] r;
    r = '0;
    if (d == 9'd1) begin
      r[16] = 1'b1;
    end else begin
      r[15:8] = 8'((d + 9'd1) >> 1);
      r[7:0]  = d[8:1];
      r[17]   = d[0];
    end
    return r;
  endfunction

  function automatic logic div_legal(input logic [8:0] d);
    return (d != 9'd0) && (d != 9'd511);
  endfunction

endpackage

// File: rtl/hdmi_pll_div_enc.sv
// rtl/hdmi_pll_div_enc.sv - combinational encoder from a divide ratio to its PLL counter register value
module hdmi_pll_div_enc
  import hdmi_pll_pkg::*;
(
  input  logic [8:0]  div,
  output logic [31:0] enc
);

  always_comb begin
    enc = div_encode(div);
  end

endmodule

// File: rtl/hdmi_pll_recfg_seq.sv
// rtl/hdmi_pll_recfg_seq.sv - sequences N/M/C0/K writes to the PLL reconfig controller and waits for relock
// Define HDMI_PLL_BW_EN to also write the bandwidth and charge-pump registers after K.
module hdmi_pll_recfg_seq
  import hdmi_pll_pkg::*;
#(
  parameter int          LOCK_TIMEOUT = 1048576,
  parameter logic [31:0] BW_VAL       = 32'h6,
  parameter logic [31:0] CP_VAL       = 32'h2
) (
  input  logic        mgmt_clk,
  input  logic        mgmt_reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [8:0]  n_div,
  input  logic [8:0]  m_div,
  input  logic [8:0]  c0_div,
  input  logic [31:0] k_frac,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CNT_W = ($clog2(LOCK_TIMEOUT + 1) > 5) ? $clog2(LOCK_TIMEOUT + 1) : 5;
  localparam logic [CNT_W-1:0] CNT_IGNORE = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

  state_e           state;
  state_e           state_nxt;
  logic [8:0]       n_q;
  logic [8:0]       m_q;
  logic [8:0]       c0_q;
  logic [31:0]      k_q;
  logic [31:0]      n_enc;
  logic [31:0]      m_enc;
  logic [31:0]      c0_enc;
  logic [1:0]       lock_sync;
  logic [CNT_W-1:0] lock_cnt;
  logic             accept;
  logic             cfg_legal;

`ifndef HDMI_PLL_BW_EN
  // The bandwidth/charge-pump values only reach the bus when those writes are built in.
  logic unused_bw_cp;
  assign unused_bw_cp = ^{BW_VAL, CP_VAL};
`endif

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_legal = div_legal(n_div) && div_legal(m_div) && div_legal(c0_div);

  hdmi_pll_div_enc u_enc_n  (.div(n_q),  .enc(n_enc));
  hdmi_pll_div_enc u_enc_m  (.div(m_q),  .enc(m_enc));
  hdmi_pll_div_enc u_enc_c0 (.div(c0_q), .enc(c0_enc));

  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset) begin
      state     <= IDLE;
      n_q       <= '0;
      m_q       <= '0;
      c0_q      <= '0;
      k_q       <= '0;
      lock_sync <= '0;
      lock_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      lock_sync <= {lock_sync[0], pll_locked};
      lock_cnt  <= (state == WAIT_LOCK) ? lock_cnt + 1'b1 : '0;
      if (accept) begin
        n_q  <= n_div;
        m_q  <= m_div;
        c0_q <= c0_div;
        k_q  <= k_frac;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_valid) state_nxt = cfg_legal ? W_MODE : ERR;
      W_MODE:  if (!mgmt_waitrequest) state_nxt = W_N;
      W_N:     if (!mgmt_waitrequest) state_nxt = W_M;
      W_M:     if (!mgmt_waitrequest) state_nxt = W_C0;
      W_C0:    if (!mgmt_waitrequest) state_nxt = W_K;
      W_K: begin
        if (!mgmt_waitrequest) begin
`ifdef HDMI_PLL_BW_EN
          state_nxt = W_BW;
`else
          state_nxt = W_START;
`endif
        end
      end
`ifdef HDMI_PLL_BW_EN
      W_BW:    if (!mgmt_waitrequest) state_nxt = W_CP;
      W_CP:    if (!mgmt_waitrequest) state_nxt = W_START;
`endif
      W_START: if (!mgmt_waitrequest) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock is trusted only after the PLL has had time to drop its old lock.
        if ((lock_cnt >= CNT_IGNORE) && lock_sync[1]) state_nxt = DONE;
        else if (lock_cnt == CNT_LAST)                state_nxt = ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write states drive the bus; every other state leaves it idle with zeros.
  always_comb begin
    mgmt_write     = 1'b1;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    case (state)
      W_MODE:  mgmt_address = ADDR_MODE;
      W_N:     begin mgmt_address = ADDR_N;  mgmt_writedata = n_enc;  end
      W_M:     begin mgmt_address = ADDR_M;  mgmt_writedata = m_enc;  end
      W_C0:    begin mgmt_address = ADDR_C0; mgmt_writedata = c0_enc; end
      W_K:     begin mgmt_address = ADDR_K;  mgmt_writedata = k_q;    end
`ifdef HDMI_PLL_BW_EN
      W_BW:    begin mgmt_address = ADDR_BW; mgmt_writedata = BW_VAL; end
      W_CP:    begin mgmt_address = ADDR_CP; mgmt_writedata = CP_VAL; end
`endif
      W_START: begin mgmt_address = ADDR_START; mgmt_writedata = 32'd1; end
      default: mgmt_write = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_hdmi_pll_recfg_seq.sv
// tb/tb_hdmi_pll_recfg_seq.sv - self-checking bench for hdmi_pll_recfg_seq (vector table plus random settings)
// Expected write lists follow HDMI_PLL_BW_EN when it is defined.
module tb_hdmi_pll_recfg_seq;

  localparam int LOCK_TO = 100;

  logic        mgmt_clk = 1'b0;
  logic        mgmt_reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [8:0]  n_div;
  logic [8:0]  m_div;
  logic [8:0]  c0_div;
  logic [31:0] k_frac;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        busy;
  logic        done;
  logic        err;

  hdmi_pll_recfg_seq #(.LOCK_TIMEOUT(LOCK_TO)) dut (
    .mgmt_clk(mgmt_clk), .mgmt_reset(mgmt_reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .n_div(n_div), .m_div(m_div), .c0_div(c0_div), .k_frac(k_frac),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked), .busy(busy), .done(done), .err(err)
  );

  always #5 mgmt_clk = ~mgmt_clk;

  typedef struct {
    logic [8:0]  n;
    logic [8:0]  m;
    logic [8:0]  c0;
    logic [31:0] k;
    bit          ill;
    logic [31:0] en;
    logic [31:0] em;
    logic [31:0] ec;
  } vec_t;

  int checks = 0;
  int failures = 0;

  int cyc = 0, start_cyc = -1, acc_cyc = 0, done_cyc = 0, err_cyc = 0;
  int done_cnt = 0, err_cnt = 0, stall_viol = 0, idle_wr = 0, cur_len = 0;
  logic [5:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_len_q[$];

  int lock_delay = -1;
  int stall_addr = -1;
  int stall_len  = 0;
  bit rand_stall = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mgmt_clk);
    #1;
  endtask

  function automatic logic [31:0] model_enc(input int d);
    if (d == 1) return 32'h0001_0000;
    return ((d + 1) / 2) * 256 + (d / 2) + (d % 2) * 131072;
  endfunction

  function automatic logic [8:0] pick_div();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 9'd0;
    if (r == 1) return 9'd511;
    return 9'($urandom_range(1, 510));
  endfunction

  // Bus monitor: records accepted writes and pulse timing, counts protocol slips.
  initial begin : monitor
    bit          prev_stall;
    logic [5:0]  pa;
    logic [31:0] pd;
    prev_stall = 0; pa = '0; pd = '0;
    forever begin
      @(negedge mgmt_clk);
      cyc++;
      if (mgmt_reset) begin
        prev_stall = 0;
        cur_len = 0;
      end else begin
        if (prev_stall && !(mgmt_write && mgmt_address == pa && mgmt_writedata == pd)) stall_viol++;
        if (!busy && mgmt_write) idle_wr++;
        if (mgmt_write) begin
          cur_len++;
          if (!mgmt_waitrequest) begin
            wr_addr_q.push_back(mgmt_address);
            wr_data_q.push_back(mgmt_writedata);
            wr_len_q.push_back(cur_len);
            cur_len = 0;
            if (mgmt_address == 6'd2) start_cyc = cyc;
          end
        end
        prev_stall = mgmt_write && mgmt_waitrequest;
        pa = mgmt_address;
        pd = mgmt_writedata;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err)  begin err_cnt++;  err_cyc  = cyc; end
        if (cfg_valid && cfg_ready) begin acc_cyc = cyc; start_cyc = -1; end
      end
    end
  end

  // Controller and PLL model: waitrequest stalls and a lock that rises lock_delay cycles after start.
  initial begin : driver
    bit in_stall;
    int left;
    in_stall = 0; left = 0;
    mgmt_waitrequest = 1'b0;
    pll_locked = 1'b0;
    forever begin
      @(posedge mgmt_clk);
      #1;
      pll_locked = (lock_delay >= 0) && (start_cyc >= 0) && ((cyc - start_cyc) >= lock_delay);
      if (mgmt_write && int'(mgmt_address) == stall_addr) begin
        if (!in_stall) begin in_stall = 1; left = stall_len; end
        mgmt_waitrequest = (left > 0);
        if (left > 0) left--;
      end else begin
        in_stall = 0;
        mgmt_waitrequest = rand_stall && mgmt_write && ($urandom_range(0, 2) == 0);
      end
    end
  end

  task automatic run_cfg(input string name, input logic [8:0] n, input logic [8:0] m,
                         input logic [8:0] c0, input logic [31:0] k, input bit ill,
                         input logic [31:0] en, input logic [31:0] em, input logic [31:0] ec,
                         input int lock_d);
    int base, d0, e0, t, nexp, nwr, lat;
    bit exp_err;
    logic [5:0]  ea[8];
    logic [31:0] ed[8];
    exp_err = ill || (lock_d < 0);
    lock_delay = lock_d;
    t = 0;
    while (!cfg_ready && t < 200) begin tick(); t++; end
    check({name, ".ready"}, cfg_ready, 1);
    base = wr_addr_q.size(); d0 = done_cnt; e0 = err_cnt;
    cfg_valid = 1'b1; n_div = n; m_div = m; c0_div = c0; k_frac = k;
    tick();
    cfg_valid = 1'b0;
    n_div = 9'($urandom); m_div = 9'($urandom); c0_div = 9'($urandom); k_frac = $urandom;
    check({name, ".busy"}, busy, 1);
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < 400) begin tick(); t++; end
    check({name, ".finished"}, (t < 400), 1);
    check({name, ".ready_after"}, cfg_ready, 1);
    repeat (3) tick();
    check({name, ".err_pulses"}, err_cnt - e0, exp_err);
    check({name, ".done_pulses"}, done_cnt - d0, !exp_err);
    nwr = wr_addr_q.size() - base;
    if (ill) begin
      check({name, ".no_write"}, nwr, 0);
      check({name, ".err_lat"}, err_cyc - acc_cyc, 1);
    end else begin
      nexp = 0;
      ea[nexp] = 6'd0; ed[nexp] = 32'd0; nexp++;
      ea[nexp] = 6'd3; ed[nexp] = en;    nexp++;
      ea[nexp] = 6'd4; ed[nexp] = em;    nexp++;
      ea[nexp] = 6'd5; ed[nexp] = ec;    nexp++;
      ea[nexp] = 6'd7; ed[nexp] = k;     nexp++;
`ifdef HDMI_PLL_BW_EN
      ea[nexp] = 6'd8; ed[nexp] = 32'h6; nexp++;
      ea[nexp] = 6'd9; ed[nexp] = 32'h2; nexp++;
`endif
      ea[nexp] = 6'd2; ed[nexp] = 32'd1; nexp++;
      check({name, ".n_writes"}, nwr, nexp);
      for (int i = 0; i < nexp && i < nwr; i++) begin
        check($sformatf("%s.wr%0d.addr", name, i), wr_addr_q[base + i], ea[i]);
        check($sformatf("%s.wr%0d.data", name, i), wr_data_q[base + i], ed[i]);
      end
      if (lock_d >= 0) begin
        lat = (lock_d + 2 > 16) ? lock_d + 2 : 16;
        check({name, ".done_lat"}, done_cyc - start_cyc, lat + 2);
      end else begin
        check({name, ".timeout_lat"}, err_cyc - start_cyc, LOCK_TO + 1);
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[8];
    int b, t;
    logic [8:0] rn, rm, rc;
    bit ill;

    mgmt_reset = 1'b1; cfg_valid = 1'b0;
    n_div = '0; m_div = '0; c0_div = '0; k_frac = '0;
    repeat (3) tick();
    check("reset.cfg_ready", cfg_ready, 1);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.err", err, 0);
    check("reset.mgmt_write", mgmt_write, 0);
    check("reset.mgmt_address", mgmt_address, 0);
    check("reset.mgmt_writedata", mgmt_writedata, 0);
    mgmt_reset = 1'b0;
    tick();

    tbl[0] = '{9'd1,   9'd8,   9'd6,   32'hE8F5C239, 1'b0, 32'h0001_0000, 32'h0000_0404, 32'h0000_0303};
    tbl[1] = '{9'd3,   9'd9,   9'd1,   32'h1234_5678, 1'b0, 32'h0002_0201, 32'h0002_0504, 32'h0001_0000};
    tbl[2] = '{9'd510, 9'd2,   9'd511, 32'h0,         1'b1, 32'h0,         32'h0,         32'h0};
    tbl[3] = '{9'd0,   9'd5,   9'd5,   32'h0,         1'b1, 32'h0,         32'h0,         32'h0};
    tbl[4] = '{9'd510, 9'd510, 9'd2,   32'hFFFF_FFFF, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0101};
    tbl[5] = '{9'd4,   9'd0,   9'd4,   32'h0,         1'b1, 32'h0,         32'h0,         32'h0};
    tbl[6] = '{9'd511, 9'd3,   9'd3,   32'h0,         1'b1, 32'h0,         32'h0,         32'h0};
    tbl[7] = '{9'd7,   9'd1,   9'd255, 32'h0000_0001, 1'b0, 32'h0002_0403, 32'h0001_0000, 32'h0002_807F};
    for (int i = 0; i < 8; i++) begin
      rand_stall = (i >= 2);
      run_cfg($sformatf("vec%0d", i), tbl[i].n, tbl[i].m, tbl[i].c0, tbl[i].k, tbl[i].ill,
              tbl[i].en, tbl[i].em, tbl[i].ec, (i == 0) ? 50 : 3 * i);
    end

    // Five-cycle stall on the M write: one write, held stable for six cycles.
    rand_stall = 0; stall_addr = 4; stall_len = 5;
    b = wr_addr_q.size();
    run_cfg("stall_m", 9'd2, 9'd9, 9'd3, 32'hA5A5_0F0F, 1'b0,
            32'h0000_0101, 32'h0002_0504, 32'h0002_0201, 10);
    check("stall_m.write_cycles", (wr_addr_q.size() > b + 2) ? wr_len_q[b + 2] : 0, 6);
    check("stall_m.stable", stall_viol, 0);
    stall_addr = -1; stall_len = 0;

    run_cfg("timeout", 9'd5, 9'd40, 9'd10, 32'h0BAD_F00D, 1'b0,
            model_enc(5), model_enc(40), model_enc(10), -1);

    // Reset while the K write is stalled.
    stall_addr = 7; stall_len = 50; lock_delay = -1;
    t = 0;
    while (!cfg_ready && t < 200) begin tick(); t++; end
    cfg_valid = 1'b1; n_div = 9'd12; m_div = 9'd33; c0_div = 9'd4; k_frac = 32'h1111_2222;
    tick();
    cfg_valid = 1'b0;
    t = 0;
    while (!(mgmt_write && mgmt_address == 6'd7) && t < 50) begin tick(); t++; end
    check("abort.reached_wk", (mgmt_write && mgmt_address == 6'd7), 1);
    @(negedge mgmt_clk);
    #2;
    mgmt_reset = 1'b1;
    #1;
    check("abort.mgmt_write", mgmt_write, 0);
    check("abort.cfg_ready", cfg_ready, 1);
    check("abort.busy", busy, 0);
    check("abort.mgmt_address", mgmt_address, 0);
    check("abort.mgmt_writedata", mgmt_writedata, 0);
    @(negedge mgmt_clk);
    #2;
    mgmt_reset = 1'b0;
    stall_addr = -1; stall_len = 0;
    run_cfg("after_abort", 9'd2, 9'd17, 9'd5, 32'h3333_4444, 1'b0,
            model_enc(2), model_enc(17), model_enc(5), 25);

    rand_stall = 1;
    for (int i = 0; i < 20; i++) begin
      rn = pick_div(); rm = pick_div(); rc = pick_div();
      ill = (rn == 0 || rn == 511 || rm == 0 || rm == 511 || rc == 0 || rc == 511);
      run_cfg($sformatf("rand%0d", i), rn, rm, rc, $urandom, ill,
              model_enc(int'(rn)), model_enc(int'(rm)), model_enc(int'(rc)),
              int'($urandom_range(0, 80)));
    end

    check("global.stall_stable", stall_viol, 0);
    check("global.idle_writes", idle_wr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
